// File: rtl/fetch_stage.sv
// Stage-1 instruction fetch: owns PC and the IR2/PC2 pipeline registers, drives the
// req/ack instruction-memory handshake, with a 1-entry skid buffer and redirect squash.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  select_pc,
  input  logic        select_pc2,
  input  logic [1:0]  select_ir2,
  input  logic [31:0] jump_addr,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_output,
  output logic [31:0] pc2_output,
  output logic [31:0] ir2_output,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {StBoot, StFetch, StSquash} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc2_q, pc2_d;
  logic [31:0] ir2_q, ir2_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        ack_valid;
  logic        avail;
  logic [31:0] src_instr;
  logic [31:0] src_pc;
  logic [31:0] target;

  // SQUASH keeps presenting the old pc: the stale request must still complete.
  assign imem_req   = ((state_q == StFetch) && !buf_valid_q) || (state_q == StSquash);
  assign imem_addr  = pc_q;
  assign pc_output  = pc_q;
  assign pc2_output = pc2_q;
  assign ir2_output = ir2_q;

  // An ack without an outstanding request is a protocol error and is dropped.
  assign ack_valid = imem_ack && imem_req;
  assign avail     = buf_valid_q || ((state_q == StFetch) && ack_valid);
  assign src_instr = buf_valid_q ? buf_q : imem_rdata;
  assign src_pc    = buf_valid_q ? buf_pc_q : pc_q;
  assign target    = (select_pc == 2'd0) ? jump_addr : branch_addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc2_d       = pc2_q;
    ir2_d       = ir2_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    redir_pc_d  = redir_pc_q;
    fetch_busy  = 1'b0;

    unique case (state_q)
      StBoot: state_d = StFetch;

      StFetch: begin
        unique case (select_pc)
          2'd0, 2'd3: begin
            ir2_d       = NOP_INSTR;
            buf_valid_d = 1'b0;
            if (imem_req && !ack_valid) begin
              redir_pc_d = target;
              state_d    = StSquash;
            end else begin
              pc_d = target;
            end
          end
          2'd2: begin
            if (ack_valid) begin
              buf_valid_d = 1'b1;
              buf_d       = imem_rdata;
              buf_pc_d    = pc_q;
            end
          end
          default: begin
            if (avail) begin
              pc_d        = pc_q + 32'd4;
              buf_valid_d = 1'b0;
              unique case (select_ir2)
                2'd0: begin
                  ir2_d = src_instr;
                  if (!select_pc2) pc2_d = src_pc;
                end
                2'd1:    ir2_d = NOP_INSTR;
                default: ir2_d = ir2_q;
              endcase
            end else begin
              fetch_busy = 1'b1;
              if (select_ir2[1] == 1'b0) ir2_d = NOP_INSTR;
            end
          end
        endcase
      end

      StSquash: begin
        ir2_d = NOP_INSTR;
        if (ack_valid) begin
          pc_d    = redir_pc_q;
          state_d = StFetch;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      pc2_q       <= 32'h0;
      ir2_q       <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      buf_q       <= 32'h0;
      buf_pc_q    <= 32'h0;
      redir_pc_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc2_q       <= pc2_d;
      ir2_q       <= ir2_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

endmodule
